ahb_arb_2m: RTL and testbench

AHB_ARB_2M -- requirements
Module: ahb_arb_2m

---
 rtl/ahb_arb_2m.sv | 198 +++++++++++++++++++
 tb/tb_ahb_arb_2m.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arb_2m.sv
// ahb_arb_2m: two-master AHB arbiter in front of a single sys_0 bus.
// Each master gets a one-entry pending buffer, so a master can always finish
// its address phase even when it does not own the bus. Ownership changes only
// at burst boundaries, and the current owner's transfers pass straight through.
// Optional feature macro: AHB_ARB_RR_EN selects round-robin tie-break.
// Without it, ties use fixed priority and M0 wins.
module ahb_arb_2m #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M0_HWRITE,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [DW-1:0] M0_HWDATA,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M0_HREADY,
    output logic          M1_HREADY,
    output logic [DW-1:0] M0_HRDATA,
    output logic [DW-1:0] M1_HRDATA,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    input  logic [DW-1:0] HRDATA,
    output logic          GRANT
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    // Master inputs gathered into arrays indexed by master number.
    logic [AW-1:0] maddr  [2];
    logic [1:0]    mtrans [2];
    logic          mwrite [2];
    logic [2:0]    msize  [2];

    assign maddr[0]  = M0_HADDR;
    assign maddr[1]  = M1_HADDR;
    assign mtrans[0] = M0_HTRANS;
    assign mtrans[1] = M1_HTRANS;
    assign mwrite[0] = M0_HWRITE;
    assign mwrite[1] = M1_HWRITE;
    assign msize[0]  = M0_HSIZE;
    assign msize[1]  = M1_HSIZE;

    // Control state.
    logic       aowner_q, aowner_d;
    logic       downer_q, downer_d;
    logic       dvalid_q, dvalid_d;
    logic [1:0] pv_q, pv_d;
`ifdef AHB_ARB_RR_EN
    logic       rr_q, rr_d;
`endif

    // Pending buffer payload. It is qualified by pv_q and is never reset.
    logic [AW-1:0] paddr_q  [2];
    logic [1:0]    ptrans_q [2];
    logic          pwrite_q [2];
    logic [2:0]    psize_q  [2];

    // Effective request of each master: the pending buffer wins over live inputs.
    logic [AW-1:0] eaddr  [2];
    logic [1:0]    etrans [2];
    logic          ewrite [2];
    logic [2:0]    esize  [2];
    logic [1:0]    ereq;
    logic [1:0]    mhready;
    logic [1:0]    lat;
    logic [1:0]    clr;
    logic [1:0]    own_oh;
    logic          arb_pt;
    logic          tie_win;
    logic          win;
    logic          own;

    // A master is stalled by the slave only in its own data phase.
    // It is also held off while its buffered transfer waits to issue.
    assign mhready[0] = (dvalid_q && !downer_q) ? HREADY : !pv_q[0];
    assign mhready[1] = (dvalid_q &&  downer_q) ? HREADY : !pv_q[1];

    // Select buffered or live address/control per master.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eaddr[i]  = pv_q[i] ? paddr_q[i]  : maddr[i];
            etrans[i] = pv_q[i] ? ptrans_q[i] : mtrans[i];
            ewrite[i] = pv_q[i] ? pwrite_q[i] : mwrite[i];
            esize[i]  = pv_q[i] ? psize_q[i]  : msize[i];
            ereq[i]   = pv_q[i] | mtrans[i][1];
        end
    end

    // Arbitrate at burst boundaries of the owner.
    // When no master requests, ownership stays parked on the last owner.
    always_comb begin
        arb_pt = HREADY && ((etrans[aowner_q] == TR_IDLE) || (etrans[aowner_q] == TR_NONSEQ));
`ifdef AHB_ARB_RR_EN
        tie_win = rr_q;
`else
        tie_win = 1'b0;
`endif
        win = aowner_q;
        if (ereq[0] && ereq[1]) begin
            win = tie_win;
        end else if (ereq[1]) begin
            win = 1'b1;
        end else if (ereq[0]) begin
            win = 1'b0;
        end
        own    = arb_pt ? win : aowner_q;
        own_oh = {own, !own};
    end

    // Buffer a transfer the master believes was accepted but the bus did not take.
    // The buffer is freed once its address phase completes on the bus.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lat[i]  = mtrans[i][1] && mhready[i] && !pv_q[i] && (!own_oh[i] || !HREADY);
            clr[i]  = pv_q[i] && own_oh[i] && HREADY;
            pv_d[i] = lat[i] | (pv_q[i] & ~clr[i]);
        end
    end

    // Owner and data-phase tracking advance only when the bus accepts a phase.
    always_comb begin
        aowner_d = aowner_q;
        downer_d = downer_q;
        dvalid_d = dvalid_q;
        if (HREADY) begin
            aowner_d = own;
            downer_d = own;
            dvalid_d = HTRANS[1];
        end
    end

`ifdef AHB_ARB_RR_EN
    // The master that is not granted gets preference at the next tie.
    always_comb begin
        rr_d = rr_q;
        if (arb_pt && (ereq != 2'b00)) begin
            rr_d = !own;
        end
    end
`endif

    // Control registers. Reset discards every in-flight transfer.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            aowner_q <= 1'b0;
            downer_q <= 1'b0;
            dvalid_q <= 1'b0;
            pv_q     <= 2'b00;
`ifdef AHB_ARB_RR_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            aowner_q <= aowner_d;
            downer_q <= downer_d;
            dvalid_q <= dvalid_d;
            pv_q     <= pv_d;
`ifdef AHB_ARB_RR_EN
            rr_q     <= rr_d;
`endif
        end
    end

    // Capture the address/control of a master whose transfer is being buffered.
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (lat[i]) begin
                paddr_q[i]  <= maddr[i];
                ptrans_q[i] <= mtrans[i];
                pwrite_q[i] <= mwrite[i];
                psize_q[i]  <= msize[i];
            end
        end
    end

    assign HADDR     = eaddr[own];
    assign HTRANS    = etrans[own];
    assign HWRITE    = ewrite[own];
    assign HSIZE     = esize[own];
    assign HWDATA    = downer_q ? M1_HWDATA : M0_HWDATA;
    assign GRANT     = own;
    assign M0_HREADY = mhready[0];
    assign M1_HREADY = mhready[1];
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;

endmodule

// File: tb/tb_ahb_arb_2m.sv
// tb_ahb_arb_2m: directed bench for ahb_arb_2m.
// Inputs change 1 time unit after the rising edge.
// Combinational outputs are sampled 2 time units later.
module tb_ahb_arb_2m;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] M0_HADDR, M1_HADDR;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic [63:0] M0_HWDATA, M1_HWDATA;
    logic        M0_HREADY, M1_HREADY;
    logic [63:0] M0_HRDATA, M1_HRDATA;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic [63:0] HRDATA;
    logic        GRANT;

    int checks = 0;
    int errors = 0;
    logic exp_g [4];

    ahb_arb_2m #(.AW(32), .DW(64)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M1_HADDR(M1_HADDR),
        .M0_HTRANS(M0_HTRANS), .M1_HTRANS(M1_HTRANS),
        .M0_HWRITE(M0_HWRITE), .M1_HWRITE(M1_HWRITE),
        .M0_HSIZE(M0_HSIZE), .M1_HSIZE(M1_HSIZE),
        .M0_HWDATA(M0_HWDATA), .M1_HWDATA(M1_HWDATA),
        .M0_HREADY(M0_HREADY), .M1_HREADY(M1_HREADY),
        .M0_HRDATA(M0_HRDATA), .M1_HRDATA(M1_HRDATA),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .GRANT(GRANT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_masters();
        M0_HTRANS = 2'b00;
        M1_HTRANS = 2'b00;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        HREADY = 1'b1;
        idle_masters();
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    initial begin
`ifdef AHB_ARB_RR_EN
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
`else
        exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0; exp_g[3] = 1'b0;
`endif
        HRESET = 1'b1; HREADY = 1'b1; HRDATA = 64'h0;
        M0_HADDR = '0; M1_HADDR = '0; M0_HWRITE = 1'b0; M1_HWRITE = 1'b0;
        M0_HSIZE = 3'b010; M1_HSIZE = 3'b010;
        M0_HWDATA = 64'h11; M1_HWDATA = 64'hA5;
        idle_masters();

        // Reset state and HRDATA broadcast.
        #2;
        HRDATA = 64'hDEAD_BEEF_0123_4567;
        #1;
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_grant", GRANT, 1'b0);
        chk("rst_m0rdy", M0_HREADY, 1'b1);
        chk("rst_m1rdy", M1_HREADY, 1'b1);
        chk("rdata_m0", M0_HRDATA, 64'hDEAD_BEEF_0123_4567);
        chk("rdata_m1", M1_HRDATA, 64'hDEAD_BEEF_0123_4567);
        do_reset();

        // M0 alone: single reads to 0x10 pass straight through.
        for (int k = 0; k < 3; k++) begin
            M0_HADDR = 32'h10; M0_HTRANS = 2'b10; M0_HWRITE = 1'b0;
            settle();
            chk("m0only_haddr", HADDR, 32'h10);
            chk("m0only_htrans", HTRANS, 2'b10);
            chk("m0only_m0rdy", M0_HREADY, 1'b1);
            chk("m0only_m1rdy", M1_HREADY, 1'b1);
            chk("m0only_grant", GRANT, 1'b0);
            step();
        end
        idle_masters();
        settle();
        chk("m0only_tail_m0rdy", M0_HREADY, 1'b1);
        chk("m0only_tail_htrans", HTRANS, 2'b00);

        // Simultaneous NONSEQ, then a 3-cycle slave stall in M1's data phase.
        do_reset();
        M0_HADDR = 32'h100; M0_HTRANS = 2'b10; M0_HWRITE = 1'b0; M0_HWDATA = 64'h11;
        M1_HADDR = 32'h200; M1_HTRANS = 2'b10; M1_HWRITE = 1'b1; M1_HWDATA = 64'hA5;
        M1_HSIZE = 3'b011;
        settle();
        chk("tie_c0_grant", GRANT, 1'b0);
        chk("tie_c0_haddr", HADDR, 32'h100);
        chk("tie_c0_hwrite", HWRITE, 1'b0);
        chk("tie_c0_m1rdy", M1_HREADY, 1'b1);
        step();
        idle_masters();
        settle();
        chk("tie_c1_grant", GRANT, 1'b1);
        chk("tie_c1_haddr", HADDR, 32'h200);
        chk("tie_c1_htrans", HTRANS, 2'b10);
        chk("tie_c1_hwrite", HWRITE, 1'b1);
        chk("tie_c1_hsize", HSIZE, 3'b011);
        chk("tie_c1_m1rdy", M1_HREADY, 1'b0);
        chk("tie_c1_m0rdy", M0_HREADY, 1'b1);
        step();
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("stall_m1rdy", M1_HREADY, 1'b0);
            chk("stall_m0rdy", M0_HREADY, 1'b1);
            chk("stall_hwdata", HWDATA, 64'hA5);
            chk("stall_htrans", HTRANS, 2'b00);
            chk("stall_haddr", HADDR, 32'h200);
            step();
        end
        HREADY = 1'b1;
        settle();
        chk("stall_end_m1rdy", M1_HREADY, 1'b1);
        chk("stall_end_hwdata", HWDATA, 64'hA5);

        // M0 4-beat INCR burst; M1 requests at beat 2 and must wait for the boundary.
        do_reset();
        M1_HSIZE = 3'b010;
        M0_HADDR = 32'h40; M0_HTRANS = 2'b10; M0_HWRITE = 1'b0;
        settle();
        chk("burst_b1_grant", GRANT, 1'b0);
        chk("burst_b1_haddr", HADDR, 32'h40);
        step();
        M0_HADDR = 32'h44; M0_HTRANS = 2'b11;
        M1_HADDR = 32'h300; M1_HTRANS = 2'b10; M1_HWRITE = 1'b1;
        settle();
        chk("burst_b2_grant", GRANT, 1'b0);
        chk("burst_b2_haddr", HADDR, 32'h44);
        chk("burst_b2_m1rdy", M1_HREADY, 1'b1);
        step();
        M0_HADDR = 32'h48; M1_HTRANS = 2'b00;
        settle();
        chk("burst_b3_grant", GRANT, 1'b0);
        chk("burst_b3_haddr", HADDR, 32'h48);
        chk("burst_b3_m1rdy", M1_HREADY, 1'b0);
        step();
        M0_HADDR = 32'h4C;
        settle();
        chk("burst_b4_grant", GRANT, 1'b0);
        chk("burst_b4_htrans", HTRANS, 2'b11);
        chk("burst_b4_m1rdy", M1_HREADY, 1'b0);
        step();
        M0_HTRANS = 2'b00;
        settle();
        chk("burst_m1_grant", GRANT, 1'b1);
        chk("burst_m1_haddr", HADDR, 32'h300);
        chk("burst_m1_htrans", HTRANS, 2'b10);
        chk("burst_m1_m0rdy", M0_HREADY, 1'b1);
        step();
        settle();
        chk("burst_m1_dphase_rdy", M1_HREADY, 1'b1);
        chk("burst_after_htrans", HTRANS, 2'b00);

        // Both masters contend for four consecutive arbitrations.
        do_reset();
        M0_HADDR = 32'h500; M0_HTRANS = 2'b10; M0_HWRITE = 1'b0;
        M1_HADDR = 32'h600; M1_HTRANS = 2'b10; M1_HWRITE = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("contend_grant", GRANT, exp_g[k]);
            chk("contend_haddr", HADDR, exp_g[k] ? 32'h600 : 32'h500);
            step();
        end

        // Reset in the middle of a buffered M1 transfer.
        do_reset();
        M0_HADDR = 32'h100; M0_HTRANS = 2'b10; M0_HWRITE = 1'b0;
        M1_HADDR = 32'h200; M1_HTRANS = 2'b10; M1_HWRITE = 1'b1;
        step();
        idle_masters();
        settle();
        chk("midrst_pre_m1rdy", M1_HREADY, 1'b0);
        chk("midrst_pre_grant", GRANT, 1'b1);
        #1;
        HRESET = 1'b1;
        #1;
        chk("midrst_htrans", HTRANS, 2'b00);
        chk("midrst_m0rdy", M0_HREADY, 1'b1);
        chk("midrst_m1rdy", M1_HREADY, 1'b1);
        chk("midrst_grant", GRANT, 1'b0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        settle();
        chk("postrst_htrans", HTRANS, 2'b00);
        chk("postrst_m1rdy", M1_HREADY, 1'b1);
        chk("postrst_grant", GRANT, 1'b0);
        step();
        settle();
        chk("postrst2_htrans", HTRANS, 2'b00);
        chk("postrst2_m1rdy", M1_HREADY, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
